lsu_handshake: RTL and testbench

- Parametrised load/store unit for the execute stage; succeeds the fixed-latency memory controller.
- Adds a valid/ready memory handshake with variable latency, pipeline stall generation, byte enables, misalignment and illegal-funct3 detection, and a bus timeout.
- Supports XLEN of 32 or 64.
- Sits between the stage-3 ALU address/rs2 data and the data-memory port; load results return to writeback with the destination register tag.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_lane_align.sv | 54 +++++
 rtl/lsu_handshake.sv | 166 ++++++++++++++++
 tb/tb_lsu_handshake.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_D  = 3'd3;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;
   localparam logic [2:0] F3_WU = 3'd6;

   function automatic logic [3:0] access_bytes(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 4'd1;
         2'd1:    return 4'd2;
         2'd2:    return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store replication / byte enables, load lane select / extension.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]                  funct3,
   input  logic [$clog2(XLEN/8)-1:0]   off,
   input  logic [XLEN-1:0]             wdata,
   input  logic [XLEN-1:0]             rdata,
   output logic [XLEN-1:0]             st_data,
   output logic [XLEN/8-1:0]           byte_en,
   output logic [XLEN-1:0]             ld_data
);

   localparam int NB = XLEN / 8;

   logic [NB-1:0]   size_mask;
   logic [XLEN-1:0] shifted;

   always_comb begin
      case (funct3[1:0])
         2'd0:    st_data = {NB{wdata[7:0]}};
         2'd1:    st_data = {(NB/2){wdata[15:0]}};
         2'd2:    st_data = {(XLEN/32){wdata[31:0]}};
         default: st_data = wdata;
      endcase
   end

   always_comb begin
      case (funct3[1:0])
         2'd0:    size_mask = NB'(8'h01);
         2'd1:    size_mask = NB'(8'h03);
         2'd2:    size_mask = NB'(8'h0F);
         default: size_mask = NB'(8'hFF);
      endcase
      byte_en = size_mask << off;
   end

   assign shifted = rdata >> {off, 3'b000};

   always_comb begin
      case (funct3)
         F3_B:    ld_data = XLEN'($signed(shifted[7:0]));
         F3_H:    ld_data = XLEN'($signed(shifted[15:0]));
         F3_W:    ld_data = XLEN'($signed(shifted[31:0]));
         F3_BU:   ld_data = XLEN'(shifted[7:0]);
         F3_HU:   ld_data = XLEN'(shifted[15:0]);
         F3_WU:   ld_data = XLEN'(shifted[31:0]);
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_handshake.sv
// Load/store unit with valid/ready memory handshake, stall generation and bus timeout.
//   state | meaning
//   IDLE  | no access in flight; accepts a new request
//   BUSY  | memory request held until MEM_ready or timeout
//   RESP  | one-cycle completion; load result presented, next request accepted
module lsu_handshake
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                CLK,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_store,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [4:0]          req_rd,
   output logic                stall,
   output logic                resp_valid,
   output logic [4:0]          resp_rd,
   output logic [XLEN-1:0]     resp_data,
   output logic                exc_misalign,
   output logic                exc_illegal,
   output logic                exc_timeout,
   output logic [ADDR_W-1:0]   MEM_addr,
   output logic [XLEN-1:0]     MEM_WR_out,
   output logic [XLEN/8-1:0]   MEM_byte_en,
   output logic [2:0]          MEM_type,
   output logic                MEM_rd_en,
   output logic                MEM_wr_en,
   input  logic                MEM_ready,
   input  logic [XLEN-1:0]     MEM_data
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   lsu_state_e         state;
   logic [CNT_W-1:0]   cnt;
   logic               lat_store;
   logic [OFF_W-1:0]   lat_off;
   logic [4:0]         lat_rd;

   logic               f3_legal;
   logic               misalign;
   logic [3:0]         acc_sz;
   logic               accept_ok;
   logic [2:0]         al_f3;
   logic [OFF_W-1:0]   al_off;
   logic [XLEN-1:0]    al_wdata;
   logic [NB-1:0]      al_be;
   logic [XLEN-1:0]    al_rdata;

   always_comb begin
      f3_legal = 1'b0;
      if (req_store) begin
         case (req_funct3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_D:             f3_legal = (XLEN == 64);
            default:          f3_legal = 1'b0;
         endcase
      end else begin
         case (req_funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
            F3_D, F3_WU:                    f3_legal = (XLEN == 64);
            default:                        f3_legal = 1'b0;
         endcase
      end
   end

   assign acc_sz    = access_bytes(req_funct3);
   assign misalign  = |(req_addr[2:0] & 3'(acc_sz - 4'd1));
   assign accept_ok = req_valid && (state != BUSY) && f3_legal && !misalign;

   // Reset gates stall so every output reads 0 while rst is high.
   assign stall = !rst && ((state == BUSY) || accept_ok);

   // Steering shares one aligner: request fields at acceptance, latched fields in BUSY.
   assign al_f3  = (state == BUSY) ? MEM_type : req_funct3;
   assign al_off = (state == BUSY) ? lat_off  : req_addr[OFF_W-1:0];

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .funct3  (al_f3),
      .off     (al_off),
      .wdata   (req_wdata),
      .rdata   (MEM_data),
      .st_data (al_wdata),
      .byte_en (al_be),
      .ld_data (al_rdata)
   );

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         lat_store    <= 1'b0;
         lat_off      <= '0;
         lat_rd       <= '0;
         resp_valid   <= 1'b0;
         resp_rd      <= '0;
         resp_data    <= '0;
         exc_misalign <= 1'b0;
         exc_illegal  <= 1'b0;
         exc_timeout  <= 1'b0;
         MEM_addr     <= '0;
         MEM_WR_out   <= '0;
         MEM_byte_en  <= '0;
         MEM_type     <= '0;
         MEM_rd_en    <= 1'b0;
         MEM_wr_en    <= 1'b0;
      end else begin
         resp_valid   <= 1'b0;
         exc_misalign <= 1'b0;
         exc_illegal  <= 1'b0;
         exc_timeout  <= 1'b0;
         case (state)
            IDLE, RESP: begin
               state <= IDLE;
               if (req_valid) begin
                  if (!f3_legal) begin
                     exc_illegal <= 1'b1;
                  end else if (misalign) begin
                     exc_misalign <= 1'b1;
                  end else begin
                     state       <= BUSY;
                     cnt         <= '0;
                     lat_store   <= req_store;
                     lat_off     <= req_addr[OFF_W-1:0];
                     lat_rd      <= req_rd;
                     MEM_addr    <= req_addr & ~ADDR_W'(NB - 1);
                     MEM_WR_out  <= req_store ? al_wdata : '0;
                     MEM_byte_en <= al_be;
                     MEM_type    <= req_funct3;
                     MEM_rd_en   <= !req_store;
                     MEM_wr_en   <= req_store;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (MEM_ready) begin
                  MEM_rd_en <= 1'b0;
                  MEM_wr_en <= 1'b0;
                  state     <= RESP;
                  if (!lat_store) begin
                     resp_valid <= 1'b1;
                     resp_rd    <= lat_rd;
                     resp_data  <= al_rdata;
                  end
               end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
                  MEM_rd_en   <= 1'b0;
                  MEM_wr_en   <= 1'b0;
                  exc_timeout <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench for lsu_handshake: XLEN=32 and XLEN=64 instances, both with an 8-cycle timeout.
module tb_lsu_handshake;

   logic CLK = 1'b0;
   logic rst;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   // XLEN=32 instance
   logic        req_valid, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        stall, resp_valid, exc_misalign, exc_illegal, exc_timeout;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data, mem_addr, mem_wr_out, mem_data;
   logic [3:0]  mem_byte_en;
   logic [2:0]  mem_type;
   logic        mem_rd_en, mem_wr_en, mem_ready;

   // XLEN=64 instance
   logic        w_valid, w_store;
   logic [2:0]  w_funct3;
   logic [31:0] w_addr;
   logic [63:0] w_wdata;
   logic [4:0]  w_rd;
   logic        w_stall, w_resp_valid, w_exc_misalign, w_exc_illegal, w_exc_timeout;
   logic [4:0]  w_resp_rd;
   logic [63:0] w_resp_data, w_mem_wr_out, w_mem_data;
   logic [31:0] w_mem_addr;
   logic [7:0]  w_mem_byte_en;
   logic [2:0]  w_mem_type;
   logic        w_mem_rd_en, w_mem_wr_en, w_mem_ready;

   lsu_handshake #(.XLEN(32), .ADDR_W(32), .TIMEOUT(8)) dut32 (
      .CLK(CLK), .rst(rst),
      .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .stall(stall), .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
      .exc_misalign(exc_misalign), .exc_illegal(exc_illegal), .exc_timeout(exc_timeout),
      .MEM_addr(mem_addr), .MEM_WR_out(mem_wr_out), .MEM_byte_en(mem_byte_en),
      .MEM_type(mem_type), .MEM_rd_en(mem_rd_en), .MEM_wr_en(mem_wr_en),
      .MEM_ready(mem_ready), .MEM_data(mem_data)
   );

   lsu_handshake #(.XLEN(64), .ADDR_W(32), .TIMEOUT(8)) dut64 (
      .CLK(CLK), .rst(rst),
      .req_valid(w_valid), .req_store(w_store), .req_funct3(w_funct3),
      .req_addr(w_addr), .req_wdata(w_wdata), .req_rd(w_rd),
      .stall(w_stall), .resp_valid(w_resp_valid), .resp_rd(w_resp_rd), .resp_data(w_resp_data),
      .exc_misalign(w_exc_misalign), .exc_illegal(w_exc_illegal), .exc_timeout(w_exc_timeout),
      .MEM_addr(w_mem_addr), .MEM_WR_out(w_mem_wr_out), .MEM_byte_en(w_mem_byte_en),
      .MEM_type(w_mem_type), .MEM_rd_en(w_mem_rd_en), .MEM_wr_en(w_mem_wr_en),
      .MEM_ready(w_mem_ready), .MEM_data(w_mem_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_rd     = rd;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
      mem_ready = 0; mem_data = 0;
      w_valid = 0; w_store = 0; w_funct3 = 0; w_addr = 0; w_wdata = 0; w_rd = 0;
      w_mem_ready = 0; w_mem_data = 0;
      #3;
      chk("rst_stall", stall, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_byte_en", mem_byte_en, 0);
      cyc();
      cyc();
      rst = 1'b0;
      cyc();

      // SW 0x104, ready on the 3rd BUSY cycle
      req(1, 3'd2, 32'h104, 32'hDEADBEEF, 5'd0);
      #1 chk("sw_stall_accept", stall, 1);
      cyc();
      req_valid = 0;
      chk("sw_wr_en", mem_wr_en, 1);
      chk("sw_rd_en", mem_rd_en, 0);
      chk("sw_byte_en", mem_byte_en, 4'b1111);
      chk("sw_addr", mem_addr, 32'h104);
      chk("sw_wdata", mem_wr_out, 32'hDEADBEEF);
      chk("sw_stall_b1", stall, 1);
      cyc();
      chk("sw_stall_b2", stall, 1);
      cyc();
      mem_ready = 1;
      #1 chk("sw_stall_b3", stall, 1);
      cyc();
      mem_ready = 0;
      chk("sw_resp_stall", stall, 0);
      chk("sw_no_resp", resp_valid, 0);
      chk("sw_wr_dropped", mem_wr_en, 0);
      cyc();

      // LB 0x103 then LBU 0x103 accepted in the RESP cycle
      req(0, 3'd0, 32'h103, 32'h0, 5'd5);
      #1 chk("lb_stall_accept", stall, 1);
      cyc();
      req_valid = 0;
      chk("lb_rd_en", mem_rd_en, 1);
      chk("lb_byte_en", mem_byte_en, 4'b1000);
      chk("lb_addr", mem_addr, 32'h100);
      mem_ready = 1;
      mem_data  = 32'h80FF_1234;
      cyc();
      chk("lb_resp_valid", resp_valid, 1);
      chk("lb_resp_rd", resp_rd, 5'd5);
      chk("lb_resp_data", resp_data, 32'hFFFFFF80);
      chk("lb_resp_stall", stall, 0);
      req(0, 3'd4, 32'h103, 32'h0, 5'd6);
      #1 chk("lbu_stall_accept", stall, 1);
      cyc();
      req_valid = 0;
      chk("lbu_rd_en", mem_rd_en, 1);
      chk("lbu_resp_gap", resp_valid, 0);
      cyc();
      mem_ready = 0;
      chk("lbu_resp_valid", resp_valid, 1);
      chk("lbu_resp_rd", resp_rd, 5'd6);
      chk("lbu_resp_data", resp_data, 32'h00000080);
      cyc();
      chk("lbu_pulse_end", resp_valid, 0);

      // SH 0x102
      req(1, 3'd1, 32'h102, 32'h0000ABCD, 5'd0);
      cyc();
      req_valid = 0;
      chk("sh_wdata", mem_wr_out, 32'hABCDABCD);
      chk("sh_byte_en", mem_byte_en, 4'b1100);
      chk("sh_wr_en", mem_wr_en, 1);
      mem_ready = 1;
      cyc();
      mem_ready = 0;
      chk("sh_no_resp", resp_valid, 0);
      cyc();

      // LH 0x101 misaligned
      req(0, 3'd1, 32'h101, 32'h0, 5'd3);
      #1 chk("lh_mis_stall", stall, 0);
      cyc();
      req_valid = 0;
      chk("lh_mis_exc", exc_misalign, 1);
      chk("lh_mis_rd_en", mem_rd_en, 0);
      chk("lh_mis_stall2", stall, 0);
      chk("lh_mis_no_ill", exc_illegal, 0);
      cyc();
      chk("lh_mis_pulse_end", exc_misalign, 0);
      chk("lh_mis_rd_en2", mem_rd_en, 0);

      // funct3=3 on XLEN=32 at an odd address: illegal wins over misalign
      req(0, 3'd3, 32'h101, 32'h0, 5'd3);
      #1 chk("ld32_stall", stall, 0);
      cyc();
      req_valid = 0;
      chk("ld32_illegal", exc_illegal, 1);
      chk("ld32_no_mis", exc_misalign, 0);
      chk("ld32_rd_en", mem_rd_en, 0);
      // store with funct3=4 is illegal
      req(1, 3'd4, 32'h100, 32'h0, 5'd0);
      cyc();
      req_valid = 0;
      chk("st_f3_4_illegal", exc_illegal, 1);
      chk("st_f3_4_wr_en", mem_wr_en, 0);
      cyc();

      // LW timeout: 8 BUSY cycles without ready
      req(0, 3'd2, 32'h200, 32'h0, 5'd7);
      cyc();
      req_valid = 0;
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("to_rd_en_b%0d", i), mem_rd_en, 1);
         chk($sformatf("to_no_exc_b%0d", i), exc_timeout, 0);
         cyc();
      end
      chk("to_exc", exc_timeout, 1);
      chk("to_rd_en_drop", mem_rd_en, 0);
      chk("to_stall", stall, 0);
      chk("to_no_resp", resp_valid, 0);
      // ready outside BUSY is ignored
      mem_ready = 1;
      cyc();
      chk("to_pulse_end", exc_timeout, 0);
      cyc();
      mem_ready = 0;
      chk("idle_ready_ignored", resp_valid, 0);

      // LW with ready on the 8th BUSY cycle
      mem_data = 32'h12345678;
      req(0, 3'd2, 32'h200, 32'h0, 5'd8);
      cyc();
      req_valid = 0;
      for (int i = 1; i <= 7; i++) begin
         chk($sformatf("rdy8_rd_en_b%0d", i), mem_rd_en, 1);
         cyc();
      end
      mem_ready = 1;
      chk("rdy8_rd_en_b8", mem_rd_en, 1);
      cyc();
      mem_ready = 0;
      chk("rdy8_resp_valid", resp_valid, 1);
      chk("rdy8_resp_data", resp_data, 32'h12345678);
      chk("rdy8_no_timeout", exc_timeout, 0);
      cyc();

      // Back-to-back LW/LW with immediate ready
      mem_ready = 1;
      mem_data  = 32'hA5A5A5A5;
      req(0, 3'd2, 32'h300, 32'h0, 5'd9);
      cyc();
      req(0, 3'd2, 32'h304, 32'h0, 5'd10);
      cyc();
      chk("b2b_resp1_valid", resp_valid, 1);
      chk("b2b_resp1_rd", resp_rd, 5'd9);
      chk("b2b_resp1_data", resp_data, 32'hA5A5A5A5);
      chk("b2b_accept_stall", stall, 1);
      mem_data = 32'h5A5A5A5A;
      cyc();
      req_valid = 0;
      chk("b2b_gap", resp_valid, 0);
      chk("b2b_addr2", mem_addr, 32'h304);
      chk("b2b_rd_en2", mem_rd_en, 1);
      cyc();
      mem_ready = 0;
      chk("b2b_resp2_valid", resp_valid, 1);
      chk("b2b_resp2_rd", resp_rd, 5'd10);
      chk("b2b_resp2_data", resp_data, 32'h5A5A5A5A);
      cyc();

      // Reset in BUSY clears outputs immediately
      req(0, 3'd2, 32'h400, 32'h0, 5'd4);
      cyc();
      req_valid = 0;
      chk("rb_rd_en", mem_rd_en, 1);
      #1 rst = 1'b1;
      #1;
      chk("rb_stall", stall, 0);
      chk("rb_rd_en_clr", mem_rd_en, 0);
      chk("rb_addr_clr", mem_addr, 0);
      chk("rb_type_clr", mem_type, 0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("rb_idle_rd_en", mem_rd_en, 0);
      chk("rb_idle_stall", stall, 0);

      // XLEN=64: LD 0x8 then LW 0xC back-to-back
      w_valid = 1; w_store = 0; w_funct3 = 3'd3; w_addr = 32'h8; w_rd = 5'd11;
      #1 chk("w_ld_stall", w_stall, 1);
      cyc();
      w_valid = 0;
      chk("w_ld_addr", w_mem_addr, 32'h8);
      chk("w_ld_byte_en", w_mem_byte_en, 8'hFF);
      chk("w_ld_rd_en", w_mem_rd_en, 1);
      w_mem_ready = 1;
      w_mem_data  = 64'hFEDCBA98_76543210;
      cyc();
      chk("w_ld_resp_valid", w_resp_valid, 1);
      chk("w_ld_resp_rd", w_resp_rd, 5'd11);
      chk("w_ld_resp_data", w_resp_data, 64'hFEDCBA98_76543210);
      w_valid = 1; w_funct3 = 3'd2; w_addr = 32'hC; w_rd = 5'd12;
      cyc();
      w_valid = 0;
      chk("w_lw_byte_en", w_mem_byte_en, 8'hF0);
      cyc();
      w_mem_ready = 0;
      chk("w_lw_resp_data", w_resp_data, 64'hFFFFFFFF_FEDCBA98);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
